// File: rtl/vga_text_pkg.sv
// Shared geometry, control codes and FSM encoding for the VGA text console master.
package vga_text_pkg;
    localparam int unsigned COLS          = 80;
    localparam int unsigned ROWS          = 30;
    localparam int unsigned WORDS_PER_ROW = COLS / 4;
    localparam int unsigned VRAM_WORDS    = WORDS_PER_ROW * ROWS;
    localparam int unsigned CTRL_ADDR     = 600;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;

    typedef enum logic [2:0] {
        StIdle,
        StCharWr,
        StScrollRd,
        StScrollWait,
        StScrollWr,
        StFill,
        StClear,
        StColorWr
    } state_t;
endpackage

// File: rtl/vga_text_cursor.sv
// Cursor position register; applies advance/LF/CR/BS/home and maps the cursor to a VRAM word/lane.
module vga_text_cursor
    import vga_text_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    input  logic       lf,
    input  logic       cr,
    input  logic       bs,
    input  logic       home,
    output logic [6:0] col,
    output logic [4:0] row,
    output logic [9:0] word_addr,
    output logic [1:0] lane,
    output logic       scroll_needed
);
    logic [6:0] col_d;
    logic [4:0] row_d;
    logic       last_col, last_row, row_inc;

    assign last_col      = (col == 7'(COLS - 1));
    assign last_row      = (row == 5'(ROWS - 1));
    assign row_inc       = lf | (adv & last_col);
    // The bottom row never moves down; the caller scrolls VRAM instead.
    assign scroll_needed = row_inc & last_row;
    assign word_addr     = 10'(row) * 10'(WORDS_PER_ROW) + 10'(col[6:2]);
    assign lane          = col[1:0];

    always_comb begin
        col_d = col;
        row_d = row;
        if (home) begin
            col_d = '0;
            row_d = '0;
        end else begin
            if (lf || cr || (adv && last_col)) begin
                col_d = '0;
            end else if (adv) begin
                col_d = col + 7'd1;
            end else if (bs && (col != '0)) begin
                col_d = col - 7'd1;
            end
            if (row_inc && !last_row) begin
                row_d = row + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_d;
            row <= row_d;
        end
    end
endmodule

// File: rtl/vga_text_console_master.sv
// Avalon-MM master turning a character stream into VRAM writes for the 80x30 text slave,
// with cursor tracking, scroll-by-copy, screen clear and control-register writes.
module vga_text_console_master
    import vga_text_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  BLANK      = 8'h20
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  CHAR_DATA,
    input  logic        CHAR_INV,
    input  logic        CHAR_VALID,
    output logic        CHAR_READY,
    input  logic        CLEAR_REQ,
    input  logic        COLOR_REQ,
    input  logic [31:0] COLOR_WORD,
    output logic        BUSY,
    output logic [6:0]  CURSOR_COL,
    output logic [4:0]  CURSOR_ROW,
    output logic        AVM_CS,
    output logic        AVM_READ,
    output logic        AVM_WRITE,
    output logic [9:0]  AVM_ADDR,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic [31:0] AVM_READDATA,
    input  logic        AVM_WAITREQUEST
);
    localparam logic [9:0]  LastWord  = 10'(VRAM_WORDS - 1);
    localparam logic [9:0]  FirstFill = 10'(VRAM_WORDS - WORDS_PER_ROW);
    localparam logic [9:0]  RowWords  = 10'(WORDS_PER_ROW);
    localparam logic [9:0]  CtrlWord  = 10'(CTRL_ADDR);
    localparam logic [7:0]  LastLat   = 8'(RD_LATENCY - 1);
    localparam logic [31:0] BlankWord = {4{BLANK}};

    state_t      state_q, state_d;
    logic        read_q, read_d, write_q, write_d;
    logic [9:0]  addr_q, addr_d, word_q, word_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d, color_q, color_d;
    logic [7:0]  lat_q, lat_d;
    logic        clear_pend_q, clear_pend_d, color_pend_q, color_pend_d;
    logic        ready_q, ready_d;
    logic        go_scroll;
    logic        cur_adv, cur_lf, cur_cr, cur_bs, cur_home;
    logic [9:0]  cur_addr;
    logic [1:0]  cur_lane;
    logic        scroll_needed;

    vga_text_cursor u_cursor (
        .clk           (CLK),
        .rst_n         (RESET_N),
        .adv           (cur_adv),
        .lf            (cur_lf),
        .cr            (cur_cr),
        .bs            (cur_bs),
        .home          (cur_home),
        .col           (CURSOR_COL),
        .row           (CURSOR_ROW),
        .word_addr     (cur_addr),
        .lane          (cur_lane),
        .scroll_needed (scroll_needed)
    );

    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        lat_d        = lat_q;
        clear_pend_d = clear_pend_q | CLEAR_REQ;
        color_pend_d = color_pend_q | COLOR_REQ;
        color_d      = COLOR_REQ ? COLOR_WORD : color_q;
        go_scroll    = 1'b0;
        cur_adv      = 1'b0;
        cur_lf       = 1'b0;
        cur_cr       = 1'b0;
        cur_bs       = 1'b0;
        cur_home     = 1'b0;

        case (state_q)
            StIdle: begin
                if (clear_pend_q) begin
                    clear_pend_d = 1'b0;
                    write_d      = 1'b1;
                    addr_d       = '0;
                    word_d       = '0;
                    be_d         = 4'hF;
                    wdata_d      = BlankWord;
                    state_d      = StClear;
                end else if (color_pend_q) begin
                    color_pend_d = 1'b0;
                    write_d      = 1'b1;
                    addr_d       = CtrlWord;
                    be_d         = 4'hF;
                    wdata_d      = color_q;
                    state_d      = StColorWr;
                end else if (CHAR_VALID && ready_q) begin
                    case (CHAR_DATA)
                        CH_LF: begin
                            cur_lf    = 1'b1;
                            go_scroll = scroll_needed;
                        end
                        CH_CR:   cur_cr = 1'b1;
                        CH_BS:   cur_bs = 1'b1;
                        default: begin
                            write_d = 1'b1;
                            addr_d  = cur_addr;
                            be_d    = 4'b0001 << cur_lane;
                            wdata_d = {4{CHAR_INV, CHAR_DATA[6:0]}};
                            state_d = StCharWr;
                        end
                    endcase
                end
            end
            StCharWr: begin
                if (!AVM_WAITREQUEST) begin
                    write_d   = 1'b0;
                    cur_adv   = 1'b1;
                    state_d   = StIdle;
                    go_scroll = scroll_needed;
                end
            end
            StScrollRd: begin
                if (!AVM_WAITREQUEST) begin
                    read_d  = 1'b0;
                    lat_d   = '0;
                    state_d = StScrollWait;
                end
            end
            StScrollWait: begin
                if (lat_q == LastLat) begin
                    wdata_d = AVM_READDATA;
                    write_d = 1'b1;
                    addr_d  = word_q - RowWords;
                    be_d    = 4'hF;
                    state_d = StScrollWr;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            StScrollWr: begin
                if (!AVM_WAITREQUEST) begin
                    if (word_q == LastWord) begin
                        // Copy done; keep the write strobe up and blank the bottom row.
                        word_d  = FirstFill;
                        addr_d  = FirstFill;
                        wdata_d = BlankWord;
                        state_d = StFill;
                    end else begin
                        write_d = 1'b0;
                        read_d  = 1'b1;
                        word_d  = word_q + 10'd1;
                        addr_d  = word_q + 10'd1;
                        state_d = StScrollRd;
                    end
                end
            end
            StFill, StClear: begin
                if (!AVM_WAITREQUEST) begin
                    if (word_q == LastWord) begin
                        write_d  = 1'b0;
                        cur_home = (state_q == StClear);
                        state_d  = StIdle;
                    end else begin
                        word_d = word_q + 10'd1;
                        addr_d = word_q + 10'd1;
                    end
                end
            end
            StColorWr: begin
                if (!AVM_WAITREQUEST) begin
                    write_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (go_scroll) begin
            read_d  = 1'b1;
            write_d = 1'b0;
            addr_d  = RowWords;
            word_d  = RowWords;
            be_d    = 4'hF;
            state_d = StScrollRd;
        end

        ready_d = (state_d == StIdle) & ~clear_pend_d & ~color_pend_d;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            word_q       <= '0;
            lat_q        <= '0;
            color_q      <= '0;
            clear_pend_q <= 1'b0;
            color_pend_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            lat_q        <= lat_d;
            color_q      <= color_d;
            clear_pend_q <= clear_pend_d;
            color_pend_q <= color_pend_d;
            ready_q      <= ready_d;
        end
    end

    assign CHAR_READY    = ready_q;
    assign BUSY          = (state_q != StIdle) | clear_pend_q | color_pend_q;
    assign AVM_READ      = read_q;
    assign AVM_WRITE     = write_q;
    assign AVM_CS        = read_q | write_q;
    assign AVM_ADDR      = addr_q;
    assign AVM_BYTE_EN   = be_q;
    assign AVM_WRITEDATA = wdata_q;
endmodule

// File: tb/tb_vga_text_console_master.sv
// Bench for vga_text_console_master: VRAM slave model plus an expected-transaction queue.
module tb_vga_text_console_master;
    import vga_text_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    logic        CLK = 1'b0, RESET_N = 1'b0;
    logic [7:0]  CHAR_DATA = '0;
    logic        CHAR_INV = 1'b0, CHAR_VALID = 1'b0, CHAR_READY;
    logic        CLEAR_REQ = 1'b0, COLOR_REQ = 1'b0;
    logic [31:0] COLOR_WORD = '0;
    logic        BUSY;
    logic [6:0]  CURSOR_COL;
    logic [4:0]  CURSOR_ROW;
    logic        AVM_CS, AVM_READ, AVM_WRITE;
    logic [9:0]  AVM_ADDR;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA, AVM_READDATA;
    logic        AVM_WAITREQUEST = 1'b0;

    int          tests = 0, fails = 0;
    int          exp_col = 0, exp_row = 0;
    txn_t        exp_q[$];
    txn_t        mon_t;
    logic [31:0] shadow [0:1023];
    logic [31:0] mem    [0:1023];
    logic        mem_ready = 1'b0;
    localparam logic [31:0] BlankWord = 32'h2020_2020;

    vga_text_console_master dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .CHAR_DATA       (CHAR_DATA),
        .CHAR_INV        (CHAR_INV),
        .CHAR_VALID      (CHAR_VALID),
        .CHAR_READY      (CHAR_READY),
        .CLEAR_REQ       (CLEAR_REQ),
        .COLOR_REQ       (COLOR_REQ),
        .COLOR_WORD      (COLOR_WORD),
        .BUSY            (BUSY),
        .CURSOR_COL      (CURSOR_COL),
        .CURSOR_ROW      (CURSOR_ROW),
        .AVM_CS          (AVM_CS),
        .AVM_READ        (AVM_READ),
        .AVM_WRITE       (AVM_WRITE),
        .AVM_ADDR        (AVM_ADDR),
        .AVM_BYTE_EN     (AVM_BYTE_EN),
        .AVM_WRITEDATA   (AVM_WRITEDATA),
        .AVM_READDATA    (AVM_READDATA),
        .AVM_WAITREQUEST (AVM_WAITREQUEST)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    function automatic txn_t mk(input logic wr, input int addr, input logic [3:0] be,
                                input logic [31:0] data);
        txn_t t;
        t.wr = wr; t.addr = 10'(addr); t.be = be; t.data = data;
        return t;
    endfunction

    // VRAM slave: one-cycle registered read data, byte-enabled writes.
    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (!AVM_WAITREQUEST) begin
            if (AVM_READ) AVM_READDATA <= mem[AVM_ADDR];
            if (AVM_WRITE) begin
                for (int b = 0; b < 4; b++)
                    if (AVM_BYTE_EN[b]) mem[AVM_ADDR][8*b +: 8] <= AVM_WRITEDATA[8*b +: 8];
            end
        end
    end

    // Every accepted bus cycle is compared against the head of the expected queue.
    always @(negedge CLK) begin
        if (RESET_N && AVM_CS && !AVM_WAITREQUEST) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL bus_unexpected rd=%b wr=%b addr=%0d data=%h required=no cycle",
                         AVM_READ, AVM_WRITE, AVM_ADDR, AVM_WRITEDATA);
            end else begin
                mon_t = exp_q.pop_front();
                if (AVM_READ === AVM_WRITE || AVM_WRITE !== mon_t.wr || AVM_ADDR !== mon_t.addr
                    || (mon_t.wr && (AVM_BYTE_EN !== mon_t.be || AVM_WRITEDATA !== mon_t.data))) begin
                    fails++;
                    $display("FAIL bus_txn got rd=%b wr=%b addr=%0d be=%b data=%h required wr=%b addr=%0d be=%b data=%h",
                             AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA,
                             mon_t.wr, mon_t.addr, mon_t.be, mon_t.data);
                end
            end
        end
    end

    task automatic model_scroll();
        for (int w = 20; w < 600; w++) begin
            exp_q.push_back(mk(1'b0, w, 4'hF, 32'h0));
            exp_q.push_back(mk(1'b1, w - 20, 4'hF, shadow[w]));
            shadow[w - 20] = shadow[w];
        end
        for (int w = 580; w < 600; w++) begin
            exp_q.push_back(mk(1'b1, w, 4'hF, BlankWord));
            shadow[w] = BlankWord;
        end
    endtask

    task automatic model_newline();
        if (exp_row == 29) model_scroll();
        else exp_row++;
    endtask

    task automatic model_char(input logic [7:0] c, input logic inv);
        int lin, lane;
        logic [7:0] bv;
        case (c)
            CH_LF: begin exp_col = 0; model_newline(); end
            CH_CR: exp_col = 0;
            CH_BS: if (exp_col > 0) exp_col--;
            default: begin
                lin  = exp_row * 80 + exp_col;
                lane = lin % 4;
                bv   = {inv, c[6:0]};
                exp_q.push_back(mk(1'b1, lin / 4, 4'(1 << lane), {4{bv}}));
                shadow[lin / 4][8*lane +: 8] = bv;
                if (exp_col == 79) begin exp_col = 0; model_newline(); end
                else exp_col++;
            end
        endcase
    endtask

    task automatic send_char(input logic [7:0] c, input logic inv);
        int n = 0;
        model_char(c, inv);
        @(negedge CLK);
        CHAR_DATA = c; CHAR_INV = inv; CHAR_VALID = 1'b1;
        while (!CHAR_READY && n < 5000) begin @(negedge CLK); n++; end
        if (!CHAR_READY) begin
            tests++; fails++;
            $display("FAIL char_accept_timeout ready=%b required=1", CHAR_READY);
            CHAR_VALID = 1'b0;
        end else begin
            @(posedge CLK);
            #1 CHAR_VALID = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (BUSY && n < 5000) begin @(negedge CLK); n++; end
        tests++;
        if (BUSY !== 1'b0) begin fails++; $display("FAIL busy_timeout busy=%b required=0", BUSY); end
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL txns_outstanding got=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        tests++;
        if ({AVM_CS, AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA} !== '0) begin
            fails++; $display("FAIL reset_bus cs=%b addr=%0d be=%b data=%h required all 0",
                              AVM_CS, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA);
        end
        tests++;
        if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0 || CHAR_READY !== 1'b0 || BUSY !== 1'b0) begin
            fails++; $display("FAIL reset_status col=%0d row=%0d ready=%b busy=%b required 0 0 0 0",
                              CURSOR_COL, CURSOR_ROW, CHAR_READY, BUSY);
        end
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        tests++;
        if (CHAR_READY !== 1'b1) begin
            fails++; $display("FAIL ready_after_reset got=%b required=1", CHAR_READY);
        end
    endtask

    task automatic test_char_a();
        send_char(8'h41, 1'b1);
        tests++;
        if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 10'd0 || AVM_BYTE_EN !== 4'b0001
            || AVM_WRITEDATA[7:0] !== 8'hC1) begin
            fails++; $display("FAIL char_a_write wr=%b addr=%0d be=%b byte=%h required 1 0 0001 c1",
                              AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA[7:0]);
        end
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd1 || CURSOR_ROW !== 5'd0) begin
            fails++; $display("FAIL char_a_cursor got=(%0d,%0d) required=(1,0)", CURSOR_COL, CURSOR_ROW);
        end
    endtask

    task automatic test_char_b();
        send_char(CH_LF, 1'b0);
        send_char(CH_LF, 1'b0);
        for (int i = 0; i < 6; i++) send_char(8'h61 + 8'(i), 1'b0);
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd6 || CURSOR_ROW !== 5'd2) begin
            fails++; $display("FAIL pre_b_cursor got=(%0d,%0d) required=(6,2)", CURSOR_COL, CURSOR_ROW);
        end
        send_char(8'h42, 1'b0);
        tests++;
        if (AVM_ADDR !== 10'd41 || AVM_BYTE_EN !== 4'b0100 || AVM_WRITEDATA[23:16] !== 8'h42) begin
            fails++; $display("FAIL char_b_write addr=%0d be=%b lane2=%h required 41 0100 42",
                              AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA[23:16]);
        end
        wait_idle();
    endtask

    task automatic test_control();
        int bus_seen = 0;
        for (int i = 0; i < 30; i++) send_char(8'h30 + 8'(i), 1'b0);
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd37) begin
            fails++; $display("FAIL pre_cr_col got=%0d required=37", CURSOR_COL);
        end
        send_char(CH_CR, 1'b0);
        repeat (3) begin @(negedge CLK); if (AVM_CS !== 1'b0) bus_seen++; end
        tests++;
        if (bus_seen != 0 || CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd2) begin
            fails++; $display("FAIL cr got col=%0d row=%0d bus=%0d required 0 2 0",
                              CURSOR_COL, CURSOR_ROW, bus_seen);
        end
        send_char(CH_BS, 1'b0);
        @(negedge CLK);
        tests++;
        if (CURSOR_COL !== 7'd0) begin
            fails++; $display("FAIL bs_at_zero got=%0d required=0", CURSOR_COL);
        end
        send_char(8'h7A, 1'b0);
        send_char(CH_BS, 1'b0);
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd2) begin
            fails++; $display("FAIL bs_dec got=(%0d,%0d) required=(0,2)", CURSOR_COL, CURSOR_ROW);
        end
    endtask

    task automatic test_scroll_wrap();
        while (exp_row < 29) send_char(CH_LF, 1'b0);
        while (exp_col < 79) send_char(8'h41 + 8'(exp_col % 26), 1'b0);
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd79 || CURSOR_ROW !== 5'd29) begin
            fails++; $display("FAIL pre_wrap_cursor got=(%0d,%0d) required=(79,29)", CURSOR_COL, CURSOR_ROW);
        end
        send_char(8'h23, 1'b0);
        tests++;
        if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 10'd599 || AVM_BYTE_EN !== 4'b1000) begin
            fails++; $display("FAIL wrap_write wr=%b addr=%0d be=%b required 1 599 1000",
                              AVM_WRITE, AVM_ADDR, AVM_BYTE_EN);
        end
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd29) begin
            fails++; $display("FAIL wrap_cursor got=(%0d,%0d) required=(0,29)", CURSOR_COL, CURSOR_ROW);
        end
    endtask

    task automatic test_lf_scroll();
        send_char(CH_LF, 1'b0);
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd29) begin
            fails++; $display("FAIL lf_scroll_cursor got=(%0d,%0d) required=(0,29)", CURSOR_COL, CURSOR_ROW);
        end
    endtask

    task automatic test_clear_color();
        int ready_seen = 0, n = 0;
        COLOR_WORD = 32'hCAFE_0123;
        send_char(8'h63, 1'b0);
        CLEAR_REQ = 1'b1; COLOR_REQ = 1'b1;
        for (int w = 0; w < 600; w++) begin
            exp_q.push_back(mk(1'b1, w, 4'hF, BlankWord));
            shadow[w] = BlankWord;
        end
        exp_q.push_back(mk(1'b1, 600, 4'hF, 32'hCAFE_0123));
        exp_col = 0; exp_row = 0;
        @(posedge CLK);
        #1 CLEAR_REQ = 1'b0; COLOR_REQ = 1'b0;
        @(negedge CLK);
        while (BUSY && n < 5000) begin
            if (CHAR_READY !== 1'b0) ready_seen++;
            @(negedge CLK); n++;
        end
        tests++;
        if (ready_seen != 0) begin
            fails++; $display("FAIL ready_during_clear got=%0d cycles required=0", ready_seen);
        end
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin
            fails++; $display("FAIL clear_cursor got=(%0d,%0d) required=(0,0)", CURSOR_COL, CURSOR_ROW);
        end
    endtask

    task automatic test_waitreq();
        int unstable = 0;
        @(negedge CLK);
        AVM_WAITREQUEST = 1'b1;
        send_char(8'h57, 1'b1);
        repeat (5) begin
            @(negedge CLK);
            if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 10'd0 || AVM_BYTE_EN !== 4'b0001
                || AVM_WRITEDATA !== 32'hD7D7_D7D7) unstable++;
        end
        tests++;
        if (unstable != 0) begin
            fails++; $display("FAIL waitreq_hold got=%0d unstable cycles required=0", unstable);
        end
        @(posedge CLK);
        #1 AVM_WAITREQUEST = 1'b0;
        wait_idle();
        tests++;
        if (CURSOR_COL !== 7'd1 || CURSOR_ROW !== 5'd0) begin
            fails++; $display("FAIL waitreq_cursor got=(%0d,%0d) required=(1,0)", CURSOR_COL, CURSOR_ROW);
        end
    endtask

    task automatic test_reset_mid_scroll();
        while (exp_row < 29) send_char(CH_LF, 1'b0);
        send_char(CH_LF, 1'b0);
        repeat (100) @(posedge CLK);
        tests++;
        if (BUSY !== 1'b1) begin
            fails++; $display("FAIL mid_scroll_busy got=%b required=1", BUSY);
        end
        #2 RESET_N = 1'b0;
        #1;
        tests++;
        if ({AVM_CS, AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA} !== '0
            || CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0 || CHAR_READY !== 1'b0 || BUSY !== 1'b0) begin
            fails++; $display("FAIL abort_reset cs=%b addr=%0d data=%h col=%0d row=%0d busy=%b required all 0",
                              AVM_CS, AVM_ADDR, AVM_WRITEDATA, CURSOR_COL, CURSOR_ROW, BUSY);
        end
        exp_q.delete();
        exp_col = 0; exp_row = 0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        tests++;
        if (BUSY !== 1'b0 || AVM_CS !== 1'b0 || CHAR_READY !== 1'b1) begin
            fails++; $display("FAIL after_abort busy=%b cs=%b ready=%b required 0 0 1", BUSY, AVM_CS, CHAR_READY);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
        test_reset();
        test_char_a();
        test_char_b();
        test_control();
        test_scroll_wrap();
        test_lf_scroll();
        test_clear_color();
        test_waitreq();
        test_reset_mid_scroll();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
